stack_control_unit: RTL

- Moore-style microsequencer for the multicycle stack-machine datapath. Each cycle it drives every load strobe, tri-state enable, memory strobe and ALU function select.
- Owns the 5-bit state register and exports state and nextstate to the datapath. It consumes the IR captured by the datapath.
- Supported instructions: fetch, decode, and execution of PUSH, POP, ADD, OR, INC, DEC, NOT, NEG and HALT.

---
 rtl/stack_cpu_pkg.sv | 89 ++++++++
 rtl/stack_ctrl_decode.sv | 82 ++++++++
 rtl/stack_control_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack-machine control unit: state encodings,
// ALU function codes, opcodes and the per-state strobe bundle.
package stack_cpu_pkg;

  localparam int         STATE_W   = 5;
  localparam int         FN_W      = 3;
  localparam logic [3:0] STACK_TAG = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 5'd0,
    S_F0   = 5'd1,
    S_F1   = 5'd2,
    S_DEC  = 5'd3,
    S_PU0  = 5'd4,
    S_PU1  = 5'd5,
    S_PU2  = 5'd6,
    S_PO0  = 5'd7,
    S_PO1  = 5'd8,
    S_PO2  = 5'd9,
    S_B0   = 5'd10,
    S_B1   = 5'd11,
    S_B2   = 5'd12,
    S_B3   = 5'd13,
    S_U0   = 5'd14,
    S_HALT = 5'd15
  } state_e;

  typedef enum logic [FN_W-1:0] {
    FN_DEF   = 3'd0,
    FN_TRANS = 3'd1,
    FN_INC   = 3'd2,
    FN_DEC   = 3'd3,
    FN_ADD   = 3'd4,
    FN_NOT   = 3'd5,
    FN_NEG   = 3'd6,
    FN_OR    = 3'd7
  } fn_e;

  localparam logic [3:0] OP_PUSH = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NEG  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic ld_mar;
    logic ld_ir;
    logic ld_pc;
    logic ld_sp;
    logic ld_mdr;
    logic ld_reg;
    logic ld_reg_bank;
    logic t_reg;
    logic t_reg_bank;
    logic t_sp;
    logic t_mar;
    logic t_pc;
    logic t_mdr;
    logic t_label;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic halted;
    fn_e  fn_sel;
  } ctrl_t;

  // First execute state for an opcode; HALT covers both the HALT opcode and
  // every unassigned opcode.
  function automatic state_e dispatch_target(input logic [3:0] op);
    state_e tgt;
    case (op)
      OP_PUSH:                        tgt = S_PU0;
      OP_POP:                         tgt = S_PO0;
      OP_ADD, OP_OR:                  tgt = S_B0;
      OP_INC, OP_DEC, OP_NOT, OP_NEG: tgt = S_U0;
      default:                        tgt = S_HALT;
    endcase
    return tgt;
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return (dispatch_target(op) != S_HALT) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/stack_ctrl_decode.sv
// Moore output decoder: maps the current state (and opcode, for the ALU
// function in the execute states) to the full strobe bundle.
module stack_ctrl_decode
  import stack_cpu_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.fn_sel = FN_DEF;
    case (state_i)
      S_F0: begin
        ctrl_o.t_pc   = 1'b1;
        ctrl_o.fn_sel = FN_TRANS;
        ctrl_o.ld_mar = 1'b1;
      end
      S_F1: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ir_write = 1'b1;
        ctrl_o.t_pc     = 1'b1;
        ctrl_o.fn_sel   = FN_INC;
        ctrl_o.ld_pc    = 1'b1;
      end
      S_PU0: begin
        ctrl_o.t_sp   = 1'b1;
        ctrl_o.fn_sel = FN_DEC;
        ctrl_o.ld_sp  = 1'b1;
        ctrl_o.ld_mar = 1'b1;
      end
      S_PU1: begin
        ctrl_o.t_reg_bank = 1'b1;
        ctrl_o.ld_mdr     = 1'b1;
      end
      S_PU2: ctrl_o.mem_write = 1'b1;
      S_PO0, S_B0: begin
        ctrl_o.t_sp   = 1'b1;
        ctrl_o.fn_sel = FN_TRANS;
        ctrl_o.ld_mar = 1'b1;
      end
      S_PO1: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.t_sp     = 1'b1;
        ctrl_o.fn_sel   = FN_INC;
        ctrl_o.ld_sp    = 1'b1;
      end
      S_PO2: begin
        ctrl_o.t_mdr       = 1'b1;
        ctrl_o.fn_sel      = FN_TRANS;
        ctrl_o.ld_reg_bank = 1'b1;
      end
      S_B1: ctrl_o.mem_read = 1'b1;
      S_B2: begin
        ctrl_o.t_mdr  = 1'b1;
        ctrl_o.ld_reg = 1'b1;
      end
      S_B3: begin
        ctrl_o.t_reg_bank  = 1'b1;
        ctrl_o.t_reg       = 1'b1;
        ctrl_o.ld_reg_bank = 1'b1;
        if (op_i == OP_ADD)     ctrl_o.fn_sel = FN_ADD;
        else if (op_i == OP_OR) ctrl_o.fn_sel = FN_OR;
      end
      S_U0: begin
        ctrl_o.t_reg_bank  = 1'b1;
        ctrl_o.ld_reg_bank = 1'b1;
        case (op_i)
          OP_INC:  ctrl_o.fn_sel = FN_INC;
          OP_DEC:  ctrl_o.fn_sel = FN_DEC;
          OP_NOT:  ctrl_o.fn_sel = FN_NOT;
          OP_NEG:  ctrl_o.fn_sel = FN_NEG;
          default: ctrl_o.fn_sel = FN_DEF;
        endcase
      end
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/stack_control_unit.sv
// Microsequencer for the multicycle stack-machine datapath: owns the state
// register, computes the next state and drives all strobes from the state.
module stack_control_unit
  import stack_cpu_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [15:0]        IR,
  input  logic               flag,
  output logic [FN_W-1:0]    fnSel,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] nextstate,
  output logic               ldMAR,
  output logic               ldIR,
  output logic               ldPC,
  output logic               ldSP,
  output logic               ldMDR,
  output logic               ldReg,
  output logic               ldRegBank,
  output logic               TReg,
  output logic               TRegBank,
  output logic               TSP,
  output logic               TMAR,
  output logic               TPC,
  output logic               TMDR,
  output logic               TLabel,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               halted,
  output logic               illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] op;
  logic       bad_encoding;
  ctrl_t      ctrl;

  // flag is reserved for branches; IR[15:8] belongs to the register bank.
  logic unused_bits;
  assign unused_bits = ^{flag, IR[15:8]};

  assign op           = IR[7:4];
  assign bad_encoding = (IR[3:0] != STACK_TAG) || !op_is_legal(op);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: state_d = Run ? S_F0 : S_IDLE;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_DEC;
      S_DEC: begin
        if (bad_encoding) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = dispatch_target(op);
        end
      end
      S_PU0:  state_d = S_PU1;
      S_PU1:  state_d = S_PU2;
      S_PO0:  state_d = S_PO1;
      S_PO1:  state_d = S_PO2;
      S_B0:   state_d = S_B1;
      S_B1:   state_d = S_B2;
      S_B2:   state_d = S_B3;
      // Run is only looked at once the instruction has fully retired.
      S_PU2, S_PO2, S_B3, S_U0: state_d = Run ? S_F0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  stack_ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (op),
    .ctrl_o  (ctrl)
  );

  always_comb begin
    fnSel     = ctrl.fn_sel;
    ldMAR     = ctrl.ld_mar;
    ldIR      = ctrl.ld_ir;
    ldPC      = ctrl.ld_pc;
    ldSP      = ctrl.ld_sp;
    ldMDR     = ctrl.ld_mdr;
    ldReg     = ctrl.ld_reg;
    ldRegBank = ctrl.ld_reg_bank;
    TReg      = ctrl.t_reg;
    TRegBank  = ctrl.t_reg_bank;
    TSP       = ctrl.t_sp;
    TMAR      = ctrl.t_mar;
    TPC       = ctrl.t_pc;
    TMDR      = ctrl.t_mdr;
    TLabel    = ctrl.t_label;
    MemRead   = ctrl.mem_read;
    MemWrite  = ctrl.mem_write;
    IRWrite   = ctrl.ir_write;
    halted    = ctrl.halted;
  end

  assign state     = state_q;
  assign nextstate = state_d;
  assign illegal   = illegal_q;

endmodule
